// File: rtl/sad_arb.sv
// Round-robin arbiter sharing one in-order SAD pipe between N requesters.
// Issued requester ids are queued in a tag FIFO and paired with results as they return.
module sad_arb #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned IDW   = $clog2(N),
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_vld,
  output logic [N-1:0]             req_rdy,
  input  logic [N*W-1:0]           req_x0,
  input  logic [N*W-1:0]           req_x1,
  input  logic [N*W-1:0]           req_y0,
  input  logic [N*W-1:0]           req_y1,
  output logic                     pipe_vld,
  output logic [W-1:0]             pipe_x0,
  output logic [W-1:0]             pipe_x1,
  output logic [W-1:0]             pipe_y0,
  output logic [W-1:0]             pipe_y1,
  input  logic                     pipe_rdy,
  input  logic [W+1:0]             pipe_res,
  input  logic                     pipe_res_vld,
  output logic                     pipe_res_rdy,
  output logic                     rsp_vld,
  output logic [IDW-1:0]           rsp_id,
  output logic [W+1:0]             rsp_res,
  input  logic                     rsp_rdy,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    lock_id_q, lock_id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    fifo_q [DEPTH];
  logic [IDW-1:0]    fifo_d [DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              err_q, err_d;

  logic [IDW-1:0]    rr_gnt;
  logic [IDW-1:0]    gnt;
  logic              locked;
  logic              full;
  logic              empty;
  logic              accept;
  logic              pop_req;
  logic              pop;

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    logic        found;
    rr_gnt = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req_vld[IDW'(idx)]) begin
        found  = 1'b1;
        rr_gnt = IDW'(idx);
      end
    end
  end

  // Issue side: a stalled grant is pinned until the pipe takes it.
  always_comb begin
    locked   = (state_q == ST_LOCK);
    gnt      = locked ? lock_id_q : rr_gnt;
    full     = (count_q == CNTW'(DEPTH));
    empty    = (count_q == '0);
    pipe_vld = ~full & (locked | (|req_vld));
    accept   = pipe_vld & pipe_rdy;
    req_rdy  = '0;
    pipe_x0  = '0;
    pipe_x1  = '0;
    pipe_y0  = '0;
    pipe_y1  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt == IDW'(i)) begin
        req_rdy[i] = pipe_rdy & ~full & pipe_vld;
        pipe_x0    = req_x0[i*W +: W];
        pipe_x1    = req_x1[i*W +: W];
        pipe_y0    = req_y0[i*W +: W];
        pipe_y1    = req_y1[i*W +: W];
      end
    end
  end

  // Response side is a straight pass-through tagged with the FIFO head.
  always_comb begin
    rsp_vld      = pipe_res_vld;
    rsp_res      = pipe_res;
    pipe_res_rdy = rsp_rdy;
    pop_req      = pipe_res_vld & rsp_rdy;
    pop          = pop_req & ~empty;
    rsp_id       = empty ? '0 : fifo_q[rd_ptr_q];
    inflight     = count_q;
    err          = err_q;
  end

  // Next-state: lock FSM, round-robin pointer, tag FIFO and sticky error.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    fifo_d    = fifo_q;

    if (accept) begin
      state_d          = ST_OPEN;
      rr_ptr_d         = (32'(gnt) == N - 1) ? '0 : gnt + IDW'(1);
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = wr_ptr_q + PTRW'(1);
    end else if (pipe_vld) begin
      state_d   = ST_LOCK;
      lock_id_d = gnt;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    if (pop_req && empty) begin
      err_d = 1'b1;
    end

    count_d = count_q + CNTW'(accept) - CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      fifo_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule

// File: tb/tb_sad_arb.sv
// Bench for sad_arb: behavioural SAD pipe, per-requester drivers and a response scoreboard.
module tb_sad_arb;
  localparam int W     = 8;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_vld = '0;
  logic [N-1:0]     req_rdy;
  logic [N*W-1:0]   req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
  logic             pipe_vld;
  logic [W-1:0]     pipe_x0, pipe_x1, pipe_y0, pipe_y1;
  logic             pipe_rdy;
  logic [W+1:0]     pipe_res;
  logic             pipe_res_vld;
  logic             pipe_res_rdy;
  logic             rsp_vld;
  logic [IDW-1:0]   rsp_id;
  logic [W+1:0]     rsp_res;
  logic             rsp_rdy = 1'b1;
  logic [3:0]       inflight;
  logic             err;

  typedef struct { logic [7:0] x0, x1, y0, y1; } op_t;
  typedef struct { logic [1:0] id; logic [9:0] res; } exp_t;
  typedef struct { logic [9:0] res; int rdy; } pe_t;

  op_t  rq [N][$];
  exp_t expq[$];
  pe_t  pq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int cap    = 3;
  int pq_n   = 0;
  logic       head_ok  = 1'b0;
  logic [9:0] head_res = '0;
  logic       inj      = 1'b0;
  logic [9:0] inj_res  = '0;

  logic         s_acc, s_pop, s_hd, s_rst;
  logic [N-1:0] s_take;
  logic [7:0]   s_x0, s_x1, s_y0, s_y1;

  always #5 clk = ~clk;

  sad_arb #(.W(W), .N(N), .IDW(IDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .pipe_vld(pipe_vld), .pipe_x0(pipe_x0), .pipe_x1(pipe_x1),
    .pipe_y0(pipe_y0), .pipe_y1(pipe_y1), .pipe_rdy(pipe_rdy),
    .pipe_res(pipe_res), .pipe_res_vld(pipe_res_vld), .pipe_res_rdy(pipe_res_rdy),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_rdy(rsp_rdy),
    .inflight(inflight), .err(err)
  );

  function automatic logic [9:0] sad_ref(input logic [7:0] x0, x1, y0, y1);
    logic [9:0] a, b;
    a = (x0 > y0) ? 10'(x0 - y0) : 10'(y0 - x0);
    b = (x1 > y1) ? 10'(x1 - y1) : 10'(y1 - x1);
    return a + b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int id, input logic [7:0] x0, x1, y0, y1, input logic [9:0] res);
    op_t  o;
    exp_t e;
    o.x0 = x0; o.x1 = x1; o.y0 = y0; o.y1 = y1;
    rq[id].push_back(o);
    e.id  = 2'(id);
    e.res = res;
    expq.push_back(e);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) rq[i].delete();
    expq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget, input bit rnd, output int elapsed);
    elapsed = 0;
    while ((expq.size() != 0 || pending() != 0) && elapsed < budget) begin
      if (rnd) rsp_rdy = 1'($urandom_range(0, 1));
      tick();
      elapsed++;
    end
    rsp_rdy = 1'b1;
    chk({name, "_left"}, 32'(expq.size() + pending()), 0);
    clear_all();
  endtask

  // Sample everything the models need half a cycle away from the active edge.
  always @(negedge clk) begin
    s_acc  = pipe_vld & pipe_rdy;
    s_x0   = pipe_x0; s_x1 = pipe_x1; s_y0 = pipe_y0; s_y1 = pipe_y1;
    s_pop  = pipe_res_vld & pipe_res_rdy;
    s_hd   = head_ok;
    s_rst  = rst;
    s_take = req_vld & req_rdy;
  end

  // Behavioural SAD pipe: result visible two edges after the accepting edge.
  always @(posedge clk) begin
    pe_t p;
    #1;
    cyc++;
    if (s_rst) begin
      pq.delete();
    end else begin
      if (s_pop && s_hd) void'(pq.pop_front());
      if (s_acc) begin
        p.res = sad_ref(s_x0, s_x1, s_y0, s_y1);
        p.rdy = cyc + 2;
        pq.push_back(p);
      end
    end
    pq_n     = pq.size();
    head_ok  = (pq_n > 0) && (pq[0].rdy <= cyc);
    head_res = head_ok ? pq[0].res : 10'd0;
  end

  assign pipe_res_vld = head_ok | inj;
  assign pipe_res     = inj ? inj_res : head_res;
  assign pipe_rdy     = (pq_n < cap) || (head_ok && pipe_res_rdy);

  // Requester drivers hold each op until it is taken.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_take[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_vld[i] = (rq[i].size() > 0);
      if (rq[i].size() > 0) begin
        req_x0[i*W +: W] = rq[i][0].x0;
        req_x1[i*W +: W] = rq[i][0].x1;
        req_y0[i*W +: W] = rq[i][0].y0;
        req_y1[i*W +: W] = rq[i][0].y1;
      end else begin
        req_x0[i*W +: W] = '0;
        req_x1[i*W +: W] = '0;
        req_y0[i*W +: W] = '0;
        req_y1[i*W +: W] = '0;
      end
    end
  end

  // Scoreboard monitor: every accepted response must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_vld && rsp_rdy && !inj) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d res %0d with nothing expected", rsp_id, rsp_res);
      end else begin
        e = expq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_res", 32'(rsp_res), 32'(e.res));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] a, b, c, d;

    tick(); tick();
    chk("rst_pipe_vld", 32'(pipe_vld), 0);
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_rsp_vld", 32'(rsp_vld), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();

    // Single op from requester 1.
    issue(1, 8'd3, 8'd10, 8'd20, 8'd5, 10'd22);
    t = 0;
    do begin tick(); t++; end while (!req_rdy[1] && t < 10);
    chk("t1_req_rdy", 32'(req_rdy), 32'h2);
    tick();
    chk("t1_rdy_pulse", 32'(req_rdy), 0);
    chk("t1_inflight", 32'(inflight), 1);
    tick();
    chk("t1_no_early_rsp", 32'(rsp_vld), 0);
    tick();
    chk("t1_rsp_vld", 32'(rsp_vld), 1);
    drain("t1", 20, 1'b0, t);

    // All requesters valid: strict round robin at one op per cycle.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        a = 8'(i * 17 + r * 5 + 1); b = 8'(200 - i * 9); c = 8'(i * 33 + r); d = 8'(r * 70 + 4);
        issue(i, a, b, c, d, sad_ref(a, b, c, d));
      end
    end
    drain("t2", 40, 1'b0, t);
    chk("t2_throughput", 32'(t <= 12), 1);

    // Backpressure: requester 2 is locked in while requester 0 arrives.
    cap = 3;
    rsp_rdy = 1'b0;
    issue(3, 8'd1, 8'd2, 8'd3, 8'd4, 10'd4);
    issue(3, 8'd10, 8'd0, 8'd0, 8'd10, 10'd20);
    issue(3, 8'd255, 8'd255, 8'd0, 8'd0, 10'd510);
    t = 0;
    do begin tick(); t++; end while (pipe_rdy && t < 20);
    chk("t3_pipe_stalled", 32'(pipe_rdy), 0);
    issue(2, 8'd50, 8'd60, 8'd40, 8'd80, 10'd30);
    tick();
    issue(0, 8'd7, 8'd7, 8'd7, 8'd7, 10'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_pipe_vld", 32'(pipe_vld), 1);
      chk("t3_req_rdy", 32'(req_rdy), 0);
      chk("t3_x0", 32'(pipe_x0), 50);
      chk("t3_y1", 32'(pipe_y1), 80);
    end
    chk("t3_inflight", 32'(inflight), 3);
    rsp_rdy = 1'b1;
    drain("t3", 40, 1'b0, t);

    // Fill the tag FIFO; pointer is now at 1 so requester 1 goes first.
    cap = 16;
    rsp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a = 8'(k * 11); b = 8'(k + 90); c = 8'(250 - k); d = 8'(k * 3);
      issue(1, a, b, c, d, sad_ref(a, b, c, d));
      issue(0, b, a, d, c, sad_ref(b, a, d, c));
    end
    for (int k = 0; k < 14; k++) tick();
    chk("t4_full_count", 32'(inflight), DEPTH);
    chk("t4_full_vld", 32'(pipe_vld), 0);
    chk("t4_full_rdy", 32'(req_rdy), 0);
    rsp_rdy = 1'b1;
    tick();
    chk("t4_pop_no_push", 32'(inflight), DEPTH - 1);
    tick();
    chk("t4_push_pop", 32'(inflight), DEPTH - 1);
    drain("t4", 60, 1'b0, t);

    // Wrap the FIFO several times under random response backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int j = 1; j <= N; j++) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        issue(j % N, a, b, c, d, sad_ref(a, b, c, d));
      end
    end
    drain("t5", 600, 1'b1, t);
    chk("t5_err", 32'(err), 0);

    // Reset with three ops in flight.
    cap = 3;
    rsp_rdy = 1'b0;
    for (int k = 0; k < 3; k++) issue(2, 8'(k), 8'(k + 1), 8'(9), 8'(9), 10'd0);
    t = 0;
    do begin tick(); t++; end while (inflight != 4'd3 && t < 20);
    chk("t6_inflight_pre", 32'(inflight), 3);
    rst = 1'b1;
    clear_all();
    tick();
    chk("t6_inflight", 32'(inflight), 0);
    chk("t6_rsp_vld", 32'(rsp_vld), 0);
    chk("t6_pipe_vld", 32'(pipe_vld), 0);
    rst = 1'b0;
    rsp_rdy = 1'b1;
    issue(3, 8'd100, 8'd0, 8'd0, 8'd100, 10'd200);
    drain("t6", 20, 1'b0, t);

    // Result with an empty tag FIFO: id reads 0 and err sticks until reset.
    inj_res = 10'd5;
    inj = 1'b1;
    #1;
    chk("t7_rsp_id", 32'(rsp_id), 0);
    tick();
    inj = 1'b0;
    chk("t7_err", 32'(err), 1);
    chk("t7_inflight", 32'(inflight), 0);
    tick();
    chk("t7_err_sticky", 32'(err), 1);
    do_reset();
    chk("t7_err_clear", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
